tristate_bus_xcvr: RTL

Parametrised, registered transceiver for a shared bidirectional tri-state data bus. It replaces a bare pair of tri-state buffer arrays with:
- a valid/ready send handshake;
- a bus-turnaround guard so that two agents never drive the bus at the same time;
- back-to-back burst driving;
- a registered receive path with a valid strobe.

Each agent on a shared board-level or inter-block bus instantiates one copy. External arbitration supplies `bus_busy`.

---
 rtl/tristate_bus_xcvr_if.sv | 39 +++
 rtl/tristate_bus_xcvr.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/tristate_bus_xcvr_if.sv
// Handshake, arbitration and receive-side signals of one tri-state bus agent.
// The shared data bus itself is a plain inout on the transceiver so that
// tri-state resolution happens on an ordinary board-level net.
interface tristate_bus_xcvr_if #(
    parameter int DATA_W = 32
);
    logic              snd_valid;
    logic              snd_ready;
    logic [DATA_W-1:0] out_data;
    logic              bus_busy;
    logic              rcv_en;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              drive_en;

    // Transceiver side
    modport slave (
        input  snd_valid,
        input  out_data,
        input  bus_busy,
        input  rcv_en,
        output snd_ready,
        output in_data,
        output in_valid,
        output drive_en
    );

    // User / agent logic side
    modport master (
        output snd_valid,
        output out_data,
        output bus_busy,
        output rcv_en,
        input  snd_ready,
        input  in_data,
        input  in_valid,
        input  drive_en
    );
endinterface

// File: rtl/tristate_bus_xcvr.sv
// Registered transceiver for a shared bidirectional tri-state data bus.
// Send side: valid/ready handshake, turnaround guard (TURN), back-to-back
// burst driving (DRIVE) and a mandatory one-cycle release (RELEASE) so two
// agents never overlap on the bus. Receive side: registered capture with a
// one-cycle valid strobe, independent of the send FSM.
module tristate_bus_xcvr #(
    parameter int DATA_W   = 32,
    parameter int TURN_CYC = 1,
    parameter int LOOPBACK = 0
) (
    input  logic                clk,
    input  logic                rst,
    tristate_bus_xcvr_if.slave  bus_if,
    inout  wire  [DATA_W-1:0]   data_bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TURN    = 2'd1,
        ST_DRIVE   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Turnaround reload value and the zero-turnaround shortcut
    localparam logic [3:0] TURN_INIT = 4'(TURN_CYC);
    localparam bit         ZERO_TURN = (TURN_CYC == 0);
    localparam bit         LOOP_EN   = (LOOPBACK != 0);

    state_t            state_reg;
    logic [3:0]        tcnt_reg;
    logic [DATA_W-1:0] tx_q_reg;
    logic              drive_en_reg;
    logic [DATA_W-1:0] in_data_reg;
    logic              in_valid_reg;

    logic              snd_ready_c;
    logic              handshake;
    logic              capture;

    // Ready is a decode of the current state; busy only gates it in IDLE
    // because in DRIVE this agent already owns the bus.
    always_comb begin
        snd_ready_c = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_IDLE:  snd_ready_c = !bus_if.bus_busy;
                ST_DRIVE: snd_ready_c = 1'b1;
                default:  snd_ready_c = 1'b0;
            endcase
        end
    end

    assign handshake = bus_if.snd_valid && snd_ready_c;

    // Send FSM; drive_en is registered as the decode of the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            tcnt_reg     <= 4'd0;
            tx_q_reg     <= '0;
            drive_en_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    drive_en_reg <= 1'b0;
                    if (handshake) begin
                        tx_q_reg <= bus_if.out_data;
                        tcnt_reg <= TURN_INIT;
                        if (ZERO_TURN) begin
                            state_reg    <= ST_DRIVE;
                            drive_en_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_TURN;
                        end
                    end
                end

                ST_TURN: begin
                    if (bus_if.bus_busy) begin
                        // Someone else is on the bus: restart the guard
                        tcnt_reg     <= TURN_INIT;
                        drive_en_reg <= 1'b0;
                    end else begin
                        tcnt_reg <= tcnt_reg - 4'd1;
                        if (tcnt_reg <= 4'd1) begin
                            state_reg    <= ST_DRIVE;
                            drive_en_reg <= 1'b1;
                        end else begin
                            drive_en_reg <= 1'b0;
                        end
                    end
                end

                ST_DRIVE: begin
                    if (handshake) begin
                        // Burst: next word goes out on the very next cycle
                        tx_q_reg     <= bus_if.out_data;
                        drive_en_reg <= 1'b1;
                    end else begin
                        state_reg    <= ST_RELEASE;
                        drive_en_reg <= 1'b0;
                    end
                end

                ST_RELEASE: begin
                    state_reg    <= ST_IDLE;
                    drive_en_reg <= 1'b0;
                end

                default: begin
                    state_reg    <= ST_IDLE;
                    drive_en_reg <= 1'b0;
                end
            endcase
        end
    end

    // Capture is suppressed while driving unless loopback is enabled
    assign capture = bus_if.rcv_en && (!drive_en_reg || LOOP_EN);

    // Receive register with a one-cycle valid strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            in_data_reg  <= '0;
            in_valid_reg <= 1'b0;
        end else if (capture) begin
            in_data_reg  <= data_bus;
            in_valid_reg <= 1'b1;
        end else begin
            in_valid_reg <= 1'b0;
        end
    end

    // Tri-state driver: only the registered enable ever opens it
    assign data_bus = drive_en_reg ? tx_q_reg : {DATA_W{1'bz}};

    assign bus_if.snd_ready = snd_ready_c;
    assign bus_if.in_data   = in_data_reg;
    assign bus_if.in_valid  = in_valid_reg;
    assign bus_if.drive_en  = drive_en_reg;

endmodule
